// File: rtl/label_table_pkg.sv
// Shared assembler definitions: label error codes, operation codes and
// the label character legality rule.
package label_table_pkg;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_DUP     = 3'd1,
    ERR_FULL    = 3'd2,
    ERR_LONG    = 3'd3,
    ERR_BADCHAR = 3'd4,
    ERR_EMPTY   = 3'd5,
    ERR_UNDEF   = 3'd6
  } label_err_t;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_DEFINE = 1'b1
  } label_op_t;

  // Labels are [A-Za-z0-9_], and may not start with a digit
  function automatic logic is_legal_char(input logic [7:0] c, input logic first);
    logic is_digit;
    logic is_alpha;
    logic is_under;
    is_digit = (c >= 8'h30) && (c <= 8'h39);
    is_alpha = ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    is_under = (c == 8'h5F);
    return is_alpha || is_under || (is_digit && !first);
  endfunction

endpackage

// File: rtl/label_name_accumulator.sv
// Collects label characters into a zero-padded buffer, tracking length and
// sticky LONG / BADCHAR flags. Next-state values are exported so the caller
// can act on a character arriving in the same cycle as the end marker.
module label_name_accumulator
  import label_table_pkg::*;
#(
  parameter int MAX_CHARS = 8,
  parameter int LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_char_valid,
  input  logic [7:0]             i_char,
  output logic [MAX_CHARS*8-1:0] o_name,
  output logic [LEN_W-1:0]       o_len,
  output logic [LEN_W-1:0]       o_len_nxt,
  output logic                   o_long_nxt,
  output logic                   o_bad_nxt
);

  logic [MAX_CHARS*8-1:0] r_name;
  logic [LEN_W-1:0]       r_len;
  logic                   r_long;
  logic                   r_bad;
  logic [MAX_CHARS*8-1:0] w_name_nxt;
  logic [LEN_W-1:0]       w_len_nxt;
  logic                   w_long_nxt;
  logic                   w_bad_nxt;

  // Next buffer/length/flags given this cycle's character
  always_comb begin
    w_name_nxt = r_name;
    w_len_nxt  = r_len;
    w_long_nxt = r_long;
    w_bad_nxt  = r_bad;
    if (i_char_valid) begin
      if (!is_legal_char(i_char, r_len == '0)) begin
        w_bad_nxt = 1'b1;
      end
      if (r_len == LEN_W'(MAX_CHARS)) begin
        w_long_nxt = 1'b1;
      end else begin
        for (int unsigned i = 0; i < MAX_CHARS; i++) begin
          if (r_len == LEN_W'(i)) begin
            w_name_nxt[i*8 +: 8] = i_char;
          end
        end
        w_len_nxt = r_len + 1'b1;
      end
    end
  end

  // Buffer is cleared to zero so whole-buffer compares ignore unused chars
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_name <= '0;
      r_len  <= '0;
      r_long <= 1'b0;
      r_bad  <= 1'b0;
    end else begin
      r_name <= w_name_nxt;
      r_len  <= w_len_nxt;
      r_long <= w_long_nxt;
      r_bad  <= w_bad_nxt;
    end
  end

  assign o_name     = r_name;
  assign o_len      = r_len;
  assign o_len_nxt  = w_len_nxt;
  assign o_long_nxt = w_long_nxt;
  assign o_bad_nxt  = w_bad_nxt;

endmodule

// File: rtl/label_table.sv
// Assembler label table: sequential search of defined labels, with define
// (insert) and lookup operations and PC-relative byte offset generation.
module label_table
  import label_table_pkg::*;
#(
  parameter int NUMBER_LINES = 256,
  parameter int MAX_LABELS   = 16,
  parameter int MAX_CHARS    = 8,
  parameter int ADDR_W       = $clog2(NUMBER_LINES),
  parameter int CNT_W        = $clog2(MAX_LABELS + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clear_in,
  input  logic              char_valid_in,
  input  logic [7:0]        char_in,
  input  logic              label_end_in,
  input  logic              op_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              found_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [ADDR_W+2:0] offset_out,
  output logic [2:0]        error_out,
  output logic [CNT_W-1:0]  count_out
);

  localparam int LEN_W = $clog2(MAX_CHARS + 1);
  localparam int IDX_W = $clog2(MAX_LABELS);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t                 r_state;
  label_op_t              r_op;
  logic [ADDR_W-1:0]      r_pc;
  logic [CNT_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_count;
  logic                   r_done;
  logic                   r_found;
  logic [ADDR_W-1:0]      r_addr;
  logic [ADDR_W+2:0]      r_offset;
  label_err_t             r_err;

  logic [MAX_CHARS*8-1:0] r_names [MAX_LABELS];
  logic [LEN_W-1:0]       r_lens  [MAX_LABELS];
  logic [ADDR_W-1:0]      r_addrs [MAX_LABELS];

  logic [MAX_CHARS*8-1:0] w_name;
  logic [LEN_W-1:0]       w_len;
  logic [LEN_W-1:0]       w_len_nxt;
  logic                   w_long_nxt;
  logic                   w_bad_nxt;
  logic                   w_acc_char;
  logic                   w_acc_clr;
  logic [IDX_W-1:0]       w_sel;
  logic [IDX_W-1:0]       w_wr_sel;
  logic                   w_match;
  logic [ADDR_W+2:0]      w_hit_off;

  assign w_acc_char = char_valid_in && (r_state == ST_COLLECT) && !clear_in;
  assign w_acc_clr  = clear_in || (r_state == ST_RESPOND);

  label_name_accumulator #(
    .MAX_CHARS (MAX_CHARS),
    .LEN_W     (LEN_W)
  ) u_acc (
    .i_clk        (clk_in),
    .i_rst        (rst_in),
    .i_clr        (w_acc_clr),
    .i_char_valid (w_acc_char),
    .i_char       (char_in),
    .o_name       (w_name),
    .o_len        (w_len),
    .o_len_nxt    (w_len_nxt),
    .o_long_nxt   (w_long_nxt),
    .o_bad_nxt    (w_bad_nxt)
  );

  // Entry compare and PC-relative offset for the entry under the search index
  always_comb begin
    w_sel     = r_idx[IDX_W-1:0];
    w_wr_sel  = r_count[IDX_W-1:0];
    w_match   = (r_lens[w_sel] == w_len) && (r_names[w_sel] == w_name);
    w_hit_off = ({3'b000, r_addrs[w_sel]} - {3'b000, r_pc}) << 2;
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= ST_COLLECT;
      r_op     <= OP_LOOKUP;
      r_pc     <= '0;
      r_idx    <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_addr   <= '0;
      r_offset <= '0;
      r_err    <= ERR_NONE;
    end else if (clear_in) begin
      r_state <= ST_COLLECT;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          r_done <= 1'b0;
          if (label_end_in) begin
            if (w_len_nxt == '0 || w_long_nxt || w_bad_nxt) begin
              r_state  <= ST_RESPOND;
              r_done   <= 1'b1;
              r_found  <= 1'b0;
              r_addr   <= '0;
              r_offset <= '0;
              r_err    <= (w_len_nxt == '0) ? ERR_EMPTY :
                          w_long_nxt         ? ERR_LONG  : ERR_BADCHAR;
            end else begin
              r_state <= ST_SEARCH;
              r_op    <= label_op_t'(op_in);
              r_pc    <= pc_in;
              r_idx   <= '0;
            end
          end
        end
        ST_SEARCH: begin
          if (r_idx == r_count) begin
            if (r_op == OP_DEFINE && r_count != CNT_W'(MAX_LABELS)) begin
              r_state <= ST_COMMIT;
            end else begin
              r_state  <= ST_RESPOND;
              r_done   <= 1'b1;
              r_found  <= 1'b0;
              r_addr   <= '0;
              r_offset <= '0;
              r_err    <= (r_op == OP_DEFINE) ? ERR_FULL : ERR_UNDEF;
            end
          end else if (w_match) begin
            r_state  <= ST_RESPOND;
            r_done   <= 1'b1;
            r_found  <= 1'b1;
            r_addr   <= r_addrs[w_sel];
            r_offset <= w_hit_off;
            r_err    <= (r_op == OP_DEFINE) ? ERR_DUP : ERR_NONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_state  <= ST_RESPOND;
          r_count  <= r_count + 1'b1;
          r_done   <= 1'b1;
          r_found  <= 1'b0;
          r_addr   <= r_pc;
          r_offset <= '0;
          r_err    <= ERR_NONE;
        end
        default: begin
          r_state <= ST_COLLECT;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Table storage; validity is tracked solely by r_count
  always_ff @(posedge clk_in) begin
    if (!rst_in && !clear_in && r_state == ST_COMMIT) begin
      r_names[w_wr_sel] <= w_name;
      r_lens[w_wr_sel]  <= w_len;
      r_addrs[w_wr_sel] <= r_pc;
    end
  end

  assign busy_out   = (r_state != ST_COLLECT);
  assign done_out   = r_done;
  assign found_out  = r_found;
  assign addr_out   = r_addr;
  assign offset_out = r_offset;
  assign error_out  = r_err;
  assign count_out  = r_count;

endmodule

// File: tb/tb_label_table.sv
// Scoreboard bench for label_table: stimulus pushes hand-computed responses,
// a monitor pops and compares on every done_out pulse.
module tb_label_table;
  import label_table_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        char_valid_in = 1'b0;
  logic [7:0]  char_in = '0;
  logic        label_end_in = 1'b0;
  logic        op_in = 1'b0;
  logic [7:0]  pc_in = '0;
  logic        busy_out;
  logic        done_out;
  logic        found_out;
  logic [7:0]  addr_out;
  logic [10:0] offset_out;
  logic [2:0]  error_out;
  logic [4:0]  count_out;

  label_table #(
    .NUMBER_LINES (256),
    .MAX_LABELS   (16),
    .MAX_CHARS    (8)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clear_in      (clear_in),
    .char_valid_in (char_valid_in),
    .char_in       (char_in),
    .label_end_in  (label_end_in),
    .op_in         (op_in),
    .pc_in         (pc_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .found_out     (found_out),
    .addr_out      (addr_out),
    .offset_out    (offset_out),
    .error_out     (error_out),
    .count_out     (count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int unsigned start;
    int unsigned lat;
    logic [2:0]  err;
    logic        found;
    logic        chk_addr;
    logic [7:0]  addr;
    logic [10:0] off;
    logic [4:0]  cnt;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string nm, input int unsigned act, input int unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk_in) begin
    if (done_out) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", cyc - e.start, e.lat);
        check("error",   error_out, e.err);
        check("found",   found_out, e.found);
        if (e.chk_addr) check("addr", addr_out, e.addr);
        check("offset",  offset_out, e.off);
        check("count",   count_out, e.cnt);
      end
    end
  end

  // Send a label; merge puts the last char in the label_end cycle
  task automatic send(input string nm, input logic op, input logic [7:0] pc,
                      input logic merge, input logic want,
                      input logic [2:0] e_err, input logic e_found,
                      input logic chk_addr, input logic [7:0] e_addr,
                      input logic [10:0] e_off, input logic [4:0] e_cnt,
                      input int unsigned e_lat);
    int   n;
    exp_t e;
    n = nm.len();
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
      char_valid_in = 1'b1;
      char_in = nm[i];
      if (merge && i == n - 1) begin
        label_end_in = 1'b1;
        op_in = op;
        pc_in = pc;
      end
    end
    if (!(merge && n > 0)) begin
      @(posedge clk_in); #1;
      char_valid_in = 1'b0;
      label_end_in = 1'b1;
      op_in = op;
      pc_in = pc;
    end
    e.start = cyc; e.lat = e_lat; e.err = e_err; e.found = e_found;
    e.chk_addr = chk_addr; e.addr = e_addr; e.off = e_off; e.cnt = e_cnt;
    if (want) q.push_back(e);
    @(posedge clk_in); #1;
    label_end_in = 1'b0;
    char_valid_in = 1'b0;
    if (want) begin
      for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk_in);
      if (q.size() != 0) begin
        check("response_timeout", 0, 1);
        q.delete();
      end
      @(posedge clk_in); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    // Reset state
    check("rst_done",   done_out, 0);
    check("rst_found",  found_out, 0);
    check("rst_addr",   addr_out, 0);
    check("rst_offset", offset_out, 0);
    check("rst_error",  error_out, ERR_NONE);
    check("rst_count",  count_out, 0);
    check("rst_busy",   busy_out, 0);

    // DEFINE "loop" at pc=5 into empty table
    send("loop", 1, 8'd5, 0, 1, ERR_NONE, 0, 1, 8'd5, 11'd0, 5'd1, 3);

    @(posedge clk_in); #1 clear_in = 1'b1;
    @(posedge clk_in); #1 clear_in = 1'b0;
    check("clear_count", count_out, 0);

    send("a",    1, 8'd1, 0, 1, ERR_NONE, 0, 1, 8'd1, 11'd0, 5'd1, 3);
    send("b",    1, 8'd2, 1, 1, ERR_NONE, 0, 1, 8'd2, 11'd0, 5'd2, 4);
    send("loop", 1, 8'd5, 0, 1, ERR_NONE, 0, 1, 8'd5, 11'd0, 5'd3, 5);
    // LOOKUP "loop" at pc=9: offset (5-9)*4 = -16
    send("loop", 0, 8'd9, 1, 1, ERR_NONE, 1, 1, 8'd5, 11'h7F0, 5'd3, 4);
    send("x",    0, 8'd0, 0, 1, ERR_UNDEF, 0, 0, 8'd0, 11'd0, 5'd3, 5);
    send("lo",   0, 8'd0, 0, 1, ERR_UNDEF, 0, 0, 8'd0, 11'd0, 5'd3, 5);
    // DEFINE existing "b" at pc=7: offset (2-7)*4 = -20
    send("b",    1, 8'd7, 0, 1, ERR_DUP, 1, 1, 8'd2, 11'h7EC, 5'd3, 3);

    for (int i = 3; i < 16; i++) begin
      send($sformatf("l%0d", i), 1, 8'(i), 0, 1, ERR_NONE, 0, 1, 8'(i), 11'd0, 5'(i + 1), i + 3);
    end
    send("full",     1, 8'd0,  0, 1, ERR_FULL, 0, 0, 8'd0, 11'd0, 5'd16, 18);
    send("l15",      0, 8'd20, 0, 1, ERR_NONE, 1, 1, 8'd15, 11'h7EC, 5'd16, 17);
    send("abcdefgh", 0, 8'd0,  1, 1, ERR_UNDEF, 0, 0, 8'd0, 11'd0, 5'd16, 18);
    send("9ab",      0, 8'd0,  0, 1, ERR_BADCHAR, 0, 0, 8'd0, 11'd0, 5'd16, 1);
    send("abcdefghi", 0, 8'd0, 0, 1, ERR_LONG, 0, 0, 8'd0, 11'd0, 5'd16, 1);
    send("a-bcdefghi", 1, 8'd0, 1, 1, ERR_LONG, 0, 0, 8'd0, 11'd0, 5'd16, 1);
    send("",         0, 8'd0,  0, 1, ERR_EMPTY, 0, 0, 8'd0, 11'd0, 5'd16, 1);

    // rst_in in the middle of a long search
    send("zz", 0, 8'd0, 0, 0, ERR_NONE, 0, 0, 8'd0, 11'd0, 5'd0, 0);
    repeat (4) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    repeat (20) @(posedge clk_in);
    #1;
    check("midrst_count", count_out, 0);
    check("midrst_error", error_out, ERR_NONE);
    check("midrst_found", found_out, 0);
    check("midrst_busy",  busy_out, 0);
    send("zz", 0, 8'd0, 0, 1, ERR_UNDEF, 0, 0, 8'd0, 11'd0, 5'd0, 2);

    // clear_in in the middle of a search
    send("p",  1, 8'd3, 0, 1, ERR_NONE, 0, 1, 8'd3, 11'd0, 5'd1, 3);
    send("q",  1, 8'd4, 0, 1, ERR_NONE, 0, 1, 8'd4, 11'd0, 5'd2, 4);
    send("r",  1, 8'd6, 0, 1, ERR_NONE, 0, 1, 8'd6, 11'd0, 5'd3, 5);
    send("zz", 0, 8'd0, 0, 0, ERR_NONE, 0, 0, 8'd0, 11'd0, 5'd0, 0);
    #0 clear_in = 1'b1;
    @(posedge clk_in); #1 clear_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    check("midclr_count", count_out, 0);
    send("p", 0, 8'd0, 0, 1, ERR_UNDEF, 0, 0, 8'd0, 11'd0, 5'd0, 2);

    repeat (3) @(posedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
